// File: rtl/button_event_arbiter.sv
// Turns debounced button levels into queued press events, round-robin arbitrated onto one valid/ready channel.
// Optional long-press detection is built when BTN_LONG_PRESS_EN is defined.
module button_event_arbiter #(
  parameter int N_BTN       = 4,
  parameter int IDW         = 2,
  parameter int LONG_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] button_debounced,
  output logic             event_valid,
  output logic [IDW-1:0]   event_id,
  output logic             event_long,
  input  logic             event_ready,
  output logic [N_BTN-1:0] pending,
  output logic             overrun
);

  typedef enum logic {
    S_IDLE,
    S_OFFER
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic [N_BTN-1:0] r_btn_q;
  logic [N_BTN-1:0] r_pend;
  logic [N_BTN-1:0] r_plong;
  logic             r_ovr;
  logic             r_long;
  logic [IDW-1:0]   r_id;
  logic [IDW-1:0]   r_last;
  logic [N_BTN-1:0] w_rise;
  logic [N_BTN-1:0] w_set;
  logic [N_BTN-1:0] w_set_long;
  logic [N_BTN-1:0] w_clr;
  logic [N_BTN-1:0] w_load;
  logic [IDW-1:0]   w_gnt_idx;
  logic             w_gnt_hit;
  logic             w_grant;

  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("LONG_CYCLES must be at least 2");
  end
  if ((1 << IDW) < N_BTN) begin : g_bad_idw
    $error("IDW too narrow for N_BTN");
  end

  // Loading during reset too means a button held through reset never rises.
  always_ff @(posedge clk) begin
    r_btn_q <= button_debounced;
  end

  assign w_rise = button_debounced & ~r_btn_q;

`ifdef BTN_LONG_PRESS_EN
  localparam int CW = $clog2(LONG_CYCLES + 1);
  localparam logic [CW-1:0] C_LONG = CW'(LONG_CYCLES);
  localparam logic [CW-1:0] C_PRE  = CW'(LONG_CYCLES - 1);

  logic [CW-1:0]    r_cnt [N_BTN];
  logic [N_BTN-1:0] w_fall;

  assign w_fall = ~button_debounced & r_btn_q;

  // Held through reset: park saturated so neither a long nor a short event fires.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_BTN; i++) begin
      if (!reset) begin
        r_cnt[i] <= button_debounced[i] ? C_LONG : '0;
      end else if (!button_debounced[i]) begin
        r_cnt[i] <= '0;
      end else if (w_rise[i]) begin
        r_cnt[i] <= CW'(1);
      end else if (r_cnt[i] != C_LONG) begin
        r_cnt[i] <= r_cnt[i] + CW'(1);
      end
    end
  end

  always_comb begin
    w_set      = '0;
    w_set_long = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_set_long[i] = button_debounced[i] && (r_cnt[i] == C_PRE);
      w_set[i]      = w_set_long[i] ||
                      (w_fall[i] && (r_cnt[i] != C_LONG));
    end
  end
`else
  assign w_set      = w_rise;
  assign w_set_long = '0;
`endif

  // Round-robin: first pending above last, then wrap to the low indices.
  always_comb begin
    w_gnt_hit = 1'b0;
    w_gnt_idx = '0;
    for (int j = 0; j < N_BTN; j++) begin
      if (!w_gnt_hit && r_pend[j] && (j > int'(r_last))) begin
        w_gnt_hit = 1'b1;
        w_gnt_idx = IDW'(j);
      end
    end
    for (int j = 0; j < N_BTN; j++) begin
      if (!w_gnt_hit && r_pend[j] && (j <= int'(r_last))) begin
        w_gnt_hit = 1'b1;
        w_gnt_idx = IDW'(j);
      end
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_grant   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_gnt_hit) begin
          w_grant   = 1'b1;
          w_state_n = S_OFFER;
        end
      end
      S_OFFER: begin
        if (event_ready) begin
          if (w_gnt_hit) begin
            w_grant = 1'b1;
          end else begin
            w_state_n = S_IDLE;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign w_clr  = w_grant ? (N_BTN'(1) << w_gnt_idx) : '0;
  // A new event takes the slot if it is empty or being granted this cycle.
  assign w_load = w_set & (~r_pend | w_clr);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_id    <= '0;
      r_long  <= 1'b0;
      r_last  <= IDW'(N_BTN - 1);
      r_pend  <= '0;
      r_plong <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (w_grant) begin
        r_id   <= w_gnt_idx;
        r_long <= r_plong[w_gnt_idx];
        r_last <= w_gnt_idx;
      end
      r_pend  <= (r_pend & ~w_clr) | w_set;
      r_plong <= (r_plong & ~w_load) | (w_set_long & w_load);
      if (|(w_set & r_pend & ~w_clr)) begin
        r_ovr <= 1'b1;
      end
    end
  end

  assign event_valid = (r_state == S_OFFER);
  assign event_id    = r_id;
  assign event_long  = r_long;
  assign pending     = r_pend;
  assign overrun     = r_ovr;

endmodule

// File: doc/button_event_arbiter.md
# button_event_arbiter

Controller that sits behind the per-button debouncers and turns their debounced levels into discrete button events. It detects presses per button, queues one pending event per button, and round-robin arbitrates them onto a single valid/ready event channel for the downstream control FSM. With the optional long-press feature, short and long presses are distinguished by hold time.

## Interface
- `N_BTN`, 4: number of debounced button inputs (2..16).
- `IDW`, 2: width of `event_id`; must satisfy 2^IDW ≥ N_BTN.
- `LONG_CYCLES`, 1000000: hold length, in cycles, that defines a long press. Used only with `BTN_LONG_PRESS_EN`; must be ≥ 2.
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `button_debounced` in N_BTN: debounced button levels, already synchronous to `clk`.
- `event_valid` out 1: an event is offered.
- `event_id` out IDW: index of the button that produced the event.
- `event_long` out 1: 1 = long press, 0 = short press. Tied to 0 without the macro.
- `event_ready` in 1: the consumer accepts the event.
- `pending` out N_BTN: per-button pending-event flags.
- `overrun` out 1: sticky flag; an event was lost by coalescing.

## Operation
- `btn_q` holds the previous sample of `button_debounced`.
  - While `reset` = 0, `btn_q` loads the current input. A button held through reset therefore does not produce an event.
- `rise[i] = button_debounced[i] & ~btn_q[i]` and `fall[i] = ~button_debounced[i] & btn_q[i]`.
- Event generation without the macro: a rise sets `pending[i]` with `plong[i]` = 0.
- Coalescing: if `pending[i]` is already 1 when a new event for button i arrives:
  - the existing entry is kept unchanged;
  - `overrun` is set to 1;
  - `overrun` clears only on reset.
- Arbiter FSM has two states:
  - **IDLE**: `event_valid` = 0. If any `pending` bit is set, grant the first set bit searching from `last+1` upward with wrap-around, then move to OFFER.
  - **OFFER**: `event_valid` = 1, and `event_id`/`event_long` are held stable until the handshake. On `event_valid & event_ready`:
    - if another pending bit is set, grant the next one in the same cycle and stay in OFFER;
    - otherwise go to IDLE.
- Grant action, in the granting cycle:
  - latch `event_id` and `event_long`;
  - clear the granted `pending` bit;
  - update `last` to the granted index.
- Simultaneous set and clear of the same pending bit in one cycle: set wins, so the new event stays queued.
- `event_ready` while `event_valid` = 0 is ignored.
- Reset values:
  - state = IDLE, `event_valid` = 0, `event_id` = 0, `event_long` = 0;
  - `pending` = 0, `overrun` = 0;
  - `last` = N_BTN−1, so the first grant searches from index 0.

## Timing
- Press to offer latency: input rises before edge E0; `pending` is set at E0; `event_valid` is high after E1.
- Throughput: one event per cycle while `event_ready` is held at 1.
- Fairness: a pending button waits at most N_BTN−1 grants.
- Reset asserted mid-offer: at the next edge `event_valid` = 0 and all queued events are discarded. No handshake completes in the reset cycle.
- Long-press hold counter (with the macro): per-button, `ceil(log2(LONG_CYCLES+1))` bits, saturating.
  - Cleared on rise and while the button is released.
  - Increments on each edge where the button is sampled high.

## Configuration
- `BTN_LONG_PRESS_EN` defined:
  - A rise queues nothing.
  - When the hold counter reaches `LONG_CYCLES` (button sampled high on `LONG_CYCLES` consecutive edges), queue an event with `plong` = 1, once per hold.
  - A fall before that point queues an event with `plong` = 0.
  - A fall after a long event queues nothing.
- `BTN_LONG_PRESS_EN` undefined:
  - No counters are built.
  - An event is queued on the rise; `event_long` = 0.

## Test plan
- Reset with `button_debounced` = 4'b0010 held, then release reset: no `event_valid` for 20 cycles, `pending` = 0.
- Raise button 2 only, `event_ready` = 1: `event_valid` = 1 two edges later with `event_id` = 2 for exactly one cycle, then `pending` = 0.
- Raise buttons 0, 1 and 3 in the same cycle, `event_ready` = 0 for 5 cycles, then 1:
  - `event_id` holds 0 until the handshake;
  - after the handshake, ids 1 then 3 follow on consecutive cycles.
- Press, release and press button 1 again while its first event is unaccepted: one event with `event_id` = 1 is delivered and `overrun` = 1.
- Assert reset during OFFER with `pending` = 4'b1100: the next edge gives `event_valid` = 0, `pending` = 0, `overrun` = 0.
- `BTN_LONG_PRESS_EN`, `LONG_CYCLES` = 8, button 0:
  - held 5 cycles: one event with `event_long` = 0 after release;
  - held 12 cycles: `event_long` = 1 offered two edges after the 8th high sample, and nothing on release.
